tick_scheduler: RTL

Fully synchronous, multi-channel clock-enable scheduler for the design's slow-rate consumers, such as LED blink and display refresh.
- Each channel has a programmable period counter and produces two outputs: a one-cycle tick enable and a 50% duty wave.
- All logic runs on the single system clock; no derived clocks are generated.
- Channels are reconfigured at runtime through a valid/ready config port, sequenced by a small FSM.

---
 rtl/tick_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// tick_scheduler: per-channel programmable tick enable and 50% duty wave generator. Optional macro PHASE_ALIGN_EN.
// Latency: config accepted in IDLE and applied on the following edge; tick/wave are registered.
// Backpressure: cfg_ready drops for the single APPLY cycle, so at most one config every 2 cycles.
module tick_scheduler #(
    parameter int NCH = 4,
    parameter int PW = 24,
    parameter int unsigned RST_PERIOD = 4194304,
    parameter logic [NCH-1:0] RST_EN = NCH'(1),
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_chan,
    input  logic [PW-1:0] cfg_period,
    input  logic          cfg_en,
    output logic          cfg_err,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] wave
);
    localparam logic [0:0]    IDLE  = 1'b0;
    localparam logic [0:0]    APPLY = 1'b1;
    localparam logic [CW:0]   NCH_W = (CW + 1)'(NCH);
    localparam logic [PW-1:0] RST_P = PW'(RST_PERIOD);
    localparam logic [PW-1:0] ONE   = PW'(1);

    logic [0:0]    state;
    logic [CW-1:0] lat_chan;
    logic [PW-1:0] lat_period;
    logic          lat_en;
    logic [PW-1:0] period [NCH];
    logic [PW-1:0] cnt [NCH];
    logic [NCH-1:0] en;
    logic [NCH-1:0] wr;
    logic [NCH-1:0] run;
    logic [NCH-1:0] wrap;
    logic           chan_ok;
`ifdef PHASE_ALIGN_EN
    logic [NCH-1:0] armed;
    logic           release_armed;
`endif

    assign cfg_ready = (state == IDLE);
    // Extra MSB keeps the range test meaningful when NCH is a power of two.
    assign chan_ok = ({1'b0, lat_chan} < NCH_W);

    always_comb begin
        wr   = '0;
        run  = '0;
        wrap = '0;
        for (int c = 0; c < NCH; c++) begin
            wr[c] = (state == APPLY) && chan_ok && (lat_chan == CW'(c));
`ifdef PHASE_ALIGN_EN
            run[c] = en[c] && !armed[c];
`else
            run[c] = en[c];
`endif
            wrap[c] = run[c] && (cnt[c] == period[c] - ONE);
        end
    end

`ifdef PHASE_ALIGN_EN
    // Armed channels start on channel 0's tick edge, or at once if channel 0 is stopped.
    assign release_armed = (wrap[0] && !wr[0]) || !run[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_chan   <= '0;
            lat_period <= ONE;
            lat_en     <= 1'b0;
            cfg_err    <= 1'b0;
            tick       <= '0;
            wave       <= '0;
            en         <= RST_EN;
            for (int c = 0; c < NCH; c++) begin
                period[c] <= RST_P;
                cnt[c]    <= '0;
            end
`ifdef PHASE_ALIGN_EN
            armed <= '0;
`endif
        end else begin
            cfg_err <= 1'b0;
            if (state == IDLE) begin
                if (cfg_valid) begin
                    lat_chan   <= cfg_chan;
                    lat_period <= (cfg_period == '0) ? ONE : cfg_period;
                    lat_en     <= cfg_en;
                    state      <= APPLY;
                end
            end else begin
                state   <= IDLE;
                cfg_err <= !chan_ok;
            end

            for (int c = 0; c < NCH; c++) begin
                if (wr[c]) begin
                    // A write beats a coincident terminal count: no tick for that wrap.
                    period[c] <= lat_period;
                    en[c]     <= lat_en;
                    cnt[c]    <= '0;
                    tick[c]   <= 1'b0;
                    wave[c]   <= 1'b0;
`ifdef PHASE_ALIGN_EN
                    armed[c]  <= lat_en && (c != 0) && en[0];
`endif
                end else if (wrap[c]) begin
                    cnt[c]  <= '0;
                    tick[c] <= 1'b1;
                    wave[c] <= ~wave[c];
                end else if (run[c]) begin
                    cnt[c]  <= cnt[c] + ONE;
                    tick[c] <= 1'b0;
                end else begin
                    cnt[c]  <= '0;
                    tick[c] <= 1'b0;
`ifdef PHASE_ALIGN_EN
                    if (armed[c] && release_armed)
                        armed[c] <= 1'b0;
`endif
                end
            end
        end
    end

endmodule
